rll27_decoder: RTL and testbench

- RLL(2,7) channel decoder: the receive-side stage directly downstream of the RLL(2,7) encoder.
- Consumes the encoder's channel-bit stream as 2-bit code pairs, parses the prefix-free codewords with an FSM, and pushes recovered data bits into a small bit FIFO.
- Bits leave the FIFO serially over a valid/ready handshake.
- Illegal pair sequences are flagged, counted and resynchronised.

---
 rtl/rll27_pkg.sv | 31 +++
 rtl/rll_bit_fifo.sv | 50 +++++
 rtl/rll27_decoder.sv | 116 +++++++++++
 tb/tb_rll27_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rll27_pkg.sv
// Shared types and constants for the RLL(2,7) decoder slice.
package rll27_pkg;

  localparam int unsigned MAX_WORD_BITS = 4;
  localparam int unsigned EMIT_N_W      = 3;

  localparam logic [1:0] P_00 = 2'b00;
  localparam logic [1:0] P_01 = 2'b01;
  localparam logic [1:0] P_10 = 2'b10;

  // One state per legal codeword prefix seen so far
  typedef enum logic [3:0] {
    S_IDLE,
    S_P01,
    S_P10,
    S_P1001,
    S_P00,
    S_P0001,
    S_P0010,
    S_P001001,
    S_P0000,
    S_P000010
  } state_t;

  // Decoded word: n valid bits, left-justified, first data bit in the MSB
  typedef struct packed {
    logic [EMIT_N_W-1:0]      n;
    logic [MAX_WORD_BITS-1:0] bits;
  } emit_t;

endpackage

// File: rtl/rll_bit_fifo.sv
// Bit FIFO: writes up to MAX_WORD_BITS bits per cycle, reads one bit per cycle.
module rll_bit_fifo
  import rll27_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  emit_t            push_word_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] free_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]    mem_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [EMIT_N_W-1:0] push_n;
  logic                do_pop;

  assign push_n  = push_i ? push_word_i.n : '0;
  assign do_pop  = pop_i && valid_o;
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign free_o  = CNT_W'(DEPTH) - count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(MAX_WORD_BITS); i++) begin
        if (EMIT_N_W'(i) < push_n)
          mem_q[wr_ptr_q + PTR_W'(i)] <= push_word_i.bits[MAX_WORD_BITS-1-i];
      end
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_n);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_n) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rll27_decoder.sv
// RLL(2,7) decoder: parses channel pairs into data bits, flags and counts illegal sequences.
module rll27_decoder
  import rll27_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       code_i,
  input  logic             code_valid_i,
  output logic             code_ready_o,
  output logic             data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int unsigned FREE_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q;
  state_t            nxt_state;
  emit_t             emit;
  logic              illegal;
  logic              accept;
  logic [FREE_W-1:0] free;

  assign accept = code_valid_i && code_ready_o;

  // Next state and completed word for the pair on code_i
  always_comb begin
    nxt_state = S_IDLE;
    emit      = '0;
    illegal   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if      (code_i == P_01) nxt_state = S_P01;
        else if (code_i == P_10) nxt_state = S_P10;
        else if (code_i == P_00) nxt_state = S_P00;
        else                     illegal   = 1'b1;
      end
      S_P01: begin
        if (code_i == P_00) emit = '{n: 3'd2, bits: 4'b1000};
        else                illegal = 1'b1;
      end
      S_P10: begin
        if      (code_i == P_00) emit = '{n: 3'd2, bits: 4'b1100};
        else if (code_i == P_01) nxt_state = S_P1001;
        else                     illegal = 1'b1;
      end
      S_P1001: begin
        if (code_i == P_00) emit = '{n: 3'd3, bits: 4'b0100};
        else                illegal = 1'b1;
      end
      S_P00: begin
        if      (code_i == P_01) nxt_state = S_P0001;
        else if (code_i == P_10) nxt_state = S_P0010;
        else if (code_i == P_00) nxt_state = S_P0000;
        else                     illegal   = 1'b1;
      end
      S_P0001: begin
        if (code_i == P_00) emit = '{n: 3'd3, bits: 4'b0000};
        else                illegal = 1'b1;
      end
      S_P0010: begin
        if      (code_i == P_00) emit = '{n: 3'd3, bits: 4'b0110};
        else if (code_i == P_01) nxt_state = S_P001001;
        else                     illegal = 1'b1;
      end
      S_P001001: begin
        if (code_i == P_00) emit = '{n: 3'd4, bits: 4'b0010};
        else                illegal = 1'b1;
      end
      S_P0000: begin
        if (code_i == P_10) nxt_state = S_P000010;
        else                illegal = 1'b1;
      end
      S_P000010: begin
        if (code_i == P_00) emit = '{n: 3'd4, bits: 4'b0011};
        else                illegal = 1'b1;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Ready lags the count by a cycle; safe because a word needs two accepts to complete
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      code_ready_o <= 1'b1;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      code_ready_o <= (free >= FREE_W'(MAX_WORD_BITS));
      err_o        <= accept && illegal;
      if (accept) state_q <= nxt_state;
      if (accept && illegal && (err_cnt_o != '1))
        err_cnt_o <= err_cnt_o + ERR_W'(1);
    end
  end

  rll_bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept && !illegal),
    .push_word_i (emit),
    .pop_i       (data_ready_i),
    .head_o      (data_o),
    .valid_o     (data_valid_o),
    .free_o      (free)
  );

endmodule

// File: tb/tb_rll27_decoder.sv
// Directed and randomised checks of rll27_decoder against a codeword-table encoder model.
module tb_rll27_decoder;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] code_i = 2'b00;
  logic       code_valid_i = 1'b0;
  logic       code_ready_o;
  logic       data_o;
  logic       data_valid_o;
  logic       data_ready_i = 1'b1;
  logic       err_o;
  logic [7:0] err_cnt_o;

  int n_total = 0;
  int n_pass  = 0;
  int err_pulses = 0;
  bit rand_ready = 1'b0;
  bit rand_gaps  = 1'b0;
  bit saw_stall  = 1'b0;
  logic exp_q[$];

  // Encoder model: data bits (right-justified, first bit highest) and pairs (first pair at [7:6])
  int         cw_nd [7] = '{2, 2, 3, 3, 3, 4, 4};
  logic [3:0] cw_d  [7] = '{4'b0010, 4'b0011, 4'b0000, 4'b0010, 4'b0011, 4'b0010, 4'b0011};
  int         cw_np [7] = '{2, 2, 3, 3, 3, 4, 4};
  logic [7:0] cw_p  [7] = '{8'b01000000, 8'b10000000, 8'b00010000, 8'b10010000,
                            8'b00100000, 8'b00100100, 8'b00001000};

  rll27_decoder #(.FIFO_DEPTH(8), .ERR_W(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Scoreboard: every bit the DUT hands over must match the next expected bit
  always @(negedge clk_i) begin
    if (err_o) err_pulses++;
    if (rst_i && data_valid_o && data_ready_i) begin
      if (exp_q.size() == 0) check("unexpected_bit", 32'(data_o), 32'hdead);
      else check("data_bit", 32'(data_o), 32'(exp_q.pop_front()));
    end
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rand_ready) data_ready_i = 1'($urandom_range(0, 1));
  end

  // Called just after a rising edge; returns just after the edge that accepts the pair
  task automatic send_pair(input logic [1:0] p);
    int n = 0;
    if (rand_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    code_i = p;
    code_valid_i = 1'b1;
    @(negedge clk_i);
    while (!code_ready_o && n < 1000) begin
      saw_stall = 1'b1;
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) check("accept_timeout", 32'(n), 32'(0));
    @(posedge clk_i);
    #1;
    code_valid_i = 1'b0;
  endtask

  task automatic send_word(input int idx);
    logic [3:0] d;
    logic [7:0] p;
    d = cw_d[idx];
    p = cw_p[idx];
    for (int i = cw_nd[idx] - 1; i >= 0; i--) exp_q.push_back(d[i]);
    for (int j = 0; j < cw_np[idx]; j++) send_pair(p[7-2*j -: 2]);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk_i); n++; end
    #1;
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_data_valid", 32'(data_valid_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_err_cnt", 32'(err_cnt_o), 0);
    check("rst_data", 32'(data_o), 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("ready_after_rst", 32'(code_ready_o), 1);

    // Word 10: valid rises one cycle after the final accept
    send_pair(2'b01);
    check("valid_before_end", 32'(data_valid_o), 0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    send_pair(2'b00);
    check("valid_after_end", 32'(data_valid_o), 1);
    wait_drain("drain_10");

    // Four-bit words 0011 then 0010, no errors
    err_pulses = 0;
    send_word(6);
    send_word(5);
    wait_drain("drain_4bit");
    check("no_err_pulses", 32'(err_pulses), 0);

    // Back-pressure: fill with 11 words, ready must drop, nothing lost
    data_ready_i = 1'b0;
    saw_stall = 1'b0;
    send_word(1);
    send_word(1);
    check("ready_at_4bits", 32'(code_ready_o), 1);
    send_word(1);
    fork
      send_word(1);
      begin
        repeat (5) @(negedge clk_i);
        check("ready_low_full", 32'(code_ready_o), 0);
        check("valid_full", 32'(data_valid_o), 1);
        @(posedge clk_i);
        #1;
        data_ready_i = 1'b1;
      end
    join
    wait_drain("drain_full");
    check("stall_seen", 32'(saw_stall), 1);

    // Illegal: 11 in IDLE, then 10,10
    err_pulses = 0;
    send_pair(2'b11);
    check("err_pulse_11", 32'(err_o), 1);
    send_pair(2'b10);
    check("err_cleared", 32'(err_o), 0);
    send_pair(2'b10);
    check("err_pulse_1010", 32'(err_o), 1);
    @(posedge clk_i);
    #1;
    check("err_cnt_2", 32'(err_cnt_o), 2);
    check("err_pulses_2", 32'(err_pulses), 2);
    check("no_bits_on_err", 32'(data_valid_o), 0);
    send_word(0);
    wait_drain("drain_after_err");

    // Reset mid-codeword with two bits buffered
    data_ready_i = 1'b0;
    send_word(0);
    send_pair(2'b00);
    send_pair(2'b10);
    check("buffered_valid", 32'(data_valid_o), 1);
    rst_i = 1'b0;
    #1;
    check("rst_mid_valid", 32'(data_valid_o), 0);
    check("rst_mid_err_cnt", 32'(err_cnt_o), 0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_ready_i = 1'b1;
    send_word(1);
    wait_drain("drain_after_rst");

    // Random words, random gaps on both sides
    rand_gaps = 1'b1;
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) send_word(int'($urandom_range(0, 6)));
    wait_drain("drain_random");
    rand_ready = 1'b0;
    rand_gaps = 1'b0;
    @(posedge clk_i);
    #2;
    data_ready_i = 1'b1;
    check("random_err_cnt", 32'(err_cnt_o), 0);

    // Saturation
    for (int k = 0; k < 300; k++) send_pair(2'b11);
    @(posedge clk_i);
    #1;
    check("err_cnt_sat", 32'(err_cnt_o), 255);
    send_word(2);
    wait_drain("drain_after_sat");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
